// File: rtl/cpu_mem_responder_pkg.sv
// Shared CPU type definitions used by the memory responder: FSM state
// encoding and the RV32I load/store size codes (funct3).
package pkg_cpu_typedefs;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    XFER,
    RESP
  } mem_rsp_state_t;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

endpackage

// File: rtl/cpu_mem_responder_if.sv
// Request/response bundle between the CPU (master) and the memory
// responder (slave). The request is held stable until rsp_valid.
interface cpu_mem_responder_if;

  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        busy;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_funct3, req_wdata,
    input  busy, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_funct3, req_wdata,
    output busy, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/cpu_mem_lane_align.sv
// Combinational byte-lane steering for a 32-bit little-endian word:
// builds the store byte-enable mask and replicated write data, extracts
// and extends the load lane, and classifies misaligned/illegal accesses.
module cpu_mem_lane_align
  import pkg_cpu_typedefs::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext,
  output logic        misalign,
  output logic        illegal
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  // Pick the addressed byte and halfword out of the read word.
  always_comb begin
    rbyte = rword[7:0];
    case (addr_lo)
      2'd0:    rbyte = rword[7:0];
      2'd1:    rbyte = rword[15:8];
      2'd2:    rbyte = rword[23:16];
      default: rbyte = rword[31:24];
    endcase
    rhalf = addr_lo[1] ? rword[31:16] : rword[15:0];
  end

  // Decode the size code into lane mask, write data, read extension and
  // error flags; the unsigned codes exist only for loads.
  always_comb begin
    byte_en    = 4'b0000;
    wdata_lane = 32'h0;
    rdata_ext  = 32'h0;
    misalign   = 1'b0;
    illegal    = 1'b0;
    case (funct3)
      MEM_B: begin
        byte_en    = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = {{24{rbyte[7]}}, rbyte};
      end
      MEM_H: begin
        byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = {{16{rhalf[15]}}, rhalf};
        misalign   = addr_lo[0];
      end
      MEM_W: begin
        byte_en    = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = rword;
        misalign   = (addr_lo != 2'b00);
      end
      MEM_BU: begin
        rdata_ext = {24'h0, rbyte};
        illegal   = we;
      end
      MEM_HU: begin
        rdata_ext = {16'h0, rhalf};
        misalign  = addr_lo[0];
        illegal   = we;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the multicycle CPU's shared memory port.
// Accepts one request at a time, inserts WAIT_STATES wait cycles, then
// performs the access in XFER and pulses rsp_valid for one cycle in RESP.
// DEPTH must be a power of two and at least 2.
module cpu_mem_responder
  import pkg_cpu_typedefs::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input logic                clk,
  input logic                rst,
  cpu_mem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  mem_rsp_state_t state;
  logic [3:0]     wait_cnt;

  logic           we_q;
  logic [31:0]    addr_q;
  logic [2:0]     funct3_q;
  logic [31:0]    wdata_q;

  logic [31:0]    mem [DEPTH];

  logic [AW-1:0]  word_idx;
  logic [31:0]    rword;
  logic [3:0]     byte_en;
  logic [31:0]    wdata_lane;
  logic [31:0]    rdata_ext;
  logic           misalign;
  logic           illegal;
  logic           out_of_range;
  logic           acc_err;
  logic           mem_wr;

  assign word_idx     = addr_q[AW+1:2];
  assign out_of_range = |addr_q[31:AW+2];
  assign rword        = mem[word_idx];
  assign acc_err      = misalign | illegal | out_of_range;
  // Gating with rst keeps a store from landing if reset hits during XFER.
  assign mem_wr       = (state == XFER) && we_q && !acc_err && !rst;

  cpu_mem_lane_align u_align (
    .we         (we_q),
    .funct3     (funct3_q),
    .addr_lo    (addr_q[1:0]),
    .wdata      (wdata_q),
    .rword      (rword),
    .byte_en    (byte_en),
    .wdata_lane (wdata_lane),
    .rdata_ext  (rdata_ext),
    .misalign   (misalign),
    .illegal    (illegal)
  );

  // Byte-lane write into the word array on the edge leaving XFER; the array is never reset.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      for (int k = 0; k < 4; k++) begin
        if (byte_en[k]) begin
          mem[word_idx][8*k +: 8] <= wdata_lane[8*k +: 8];
        end
      end
    end
  end

  // Request sequencing: latch in IDLE, count wait states, register the result in XFER, pulse in RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      wait_cnt      <= 4'd0;
      we_q          <= 1'b0;
      addr_q        <= 32'h0;
      funct3_q      <= 3'b000;
      wdata_q       <= 32'h0;
      bus.busy      <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= 32'h0;
      bus.rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            we_q     <= bus.req_we;
            addr_q   <= bus.req_addr;
            funct3_q <= bus.req_funct3;
            wdata_q  <= bus.req_wdata;
            bus.busy <= 1'b1;
            if (WAIT_STATES > 0) begin
              wait_cnt <= 4'(WAIT_STATES - 1);
              state    <= WAIT;
            end else begin
              state    <= XFER;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd0) begin
            state <= XFER;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        XFER: begin
          bus.rsp_err   <= acc_err;
          bus.rsp_rdata <= (!we_q && !acc_err) ? rdata_ext : 32'h0;
          bus.rsp_valid <= 1'b1;
          bus.busy      <= 1'b0;
          state         <= RESP;
        end
        RESP: begin
          bus.rsp_valid <= 1'b0;
          state         <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder: one instance with no wait states
// (functional/data checks) and one with three wait states (timing, back to
// back requests, reset mid-access). sel chooses which instance is driven.
module tb_cpu_mem_responder;
  import pkg_cpu_typedefs::*;

  logic        clk;
  logic        rst;
  logic        sel;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;

  logic        mon_busy;
  logic        mon_valid;
  logic [31:0] mon_rdata;
  logic        mon_err;

  int checks = 0;
  int errors = 0;

  cpu_mem_responder_if ifc0 ();
  cpu_mem_responder_if ifc1 ();

  assign ifc0.req_valid  = req_valid & ~sel;
  assign ifc0.req_we     = req_we;
  assign ifc0.req_addr   = req_addr;
  assign ifc0.req_funct3 = req_funct3;
  assign ifc0.req_wdata  = req_wdata;
  assign ifc1.req_valid  = req_valid & sel;
  assign ifc1.req_we     = req_we;
  assign ifc1.req_addr   = req_addr;
  assign ifc1.req_funct3 = req_funct3;
  assign ifc1.req_wdata  = req_wdata;

  assign mon_busy  = sel ? ifc1.busy      : ifc0.busy;
  assign mon_valid = sel ? ifc1.rsp_valid : ifc0.rsp_valid;
  assign mon_rdata = sel ? ifc1.rsp_rdata : ifc0.rsp_rdata;
  assign mon_err   = sel ? ifc1.rsp_err   : ifc0.rsp_err;

  cpu_mem_responder #(.DEPTH(1024), .WAIT_STATES(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (ifc0.slave)
  );

  cpu_mem_responder #(.DEPTH(1024), .WAIT_STATES(3)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (ifc1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  // Starts on a negedge, idles one cycle, issues one request and returns
  // at the negedge of the response cycle with the request withdrawn.
  task automatic apply_stimulus(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                                input logic [31:0] wd, output logic [31:0] rdata,
                                output logic err, output int lat);
    @(negedge clk);
    req_we     = we;
    req_addr   = addr;
    req_funct3 = f3;
    req_wdata  = wd;
    req_valid  = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!mon_valid && lat < 40);
    if (!mon_valid) check_output("rsp_timeout", 32'(mon_valid), 32'd1);
    rdata     = mon_rdata;
    err       = mon_err;
    req_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [7:0]  busy_tr;
    logic [7:0]  vld_tr;
    int          k;
    logic        seen;

    rst        = 1'b1;
    sel        = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = 32'h0;
    req_funct3 = MEM_W;
    req_wdata  = 32'h0;
    repeat (3) @(negedge clk);

    check_output("rst_busy",  32'(ifc0.busy), 32'd0);
    check_output("rst_valid", 32'(ifc0.rsp_valid), 32'd0);
    check_output("rst_rdata", ifc0.rsp_rdata, 32'h0);
    check_output("rst_err",   32'(ifc0.rsp_err), 32'd0);
    check_output("rst_busy1", 32'(ifc1.busy), 32'd0);
    rst = 1'b0;

    // Zero wait states: basic store/load and latency
    apply_stimulus(1'b1, 32'h10, MEM_W, 32'hDEADBEEF, rd, er, lat);
    check_output("sw_lat",   32'(lat), 32'd2);
    check_output("sw_rdata", rd, 32'h0);
    check_output("sw_err",   32'(er), 32'd0);
    apply_stimulus(1'b0, 32'h10, MEM_W, 32'h0, rd, er, lat);
    check_output("lw_lat",   32'(lat), 32'd2);
    check_output("lw_rdata", rd, 32'hDEADBEEF);
    check_output("lw_err",   32'(er), 32'd0);
    @(negedge clk);
    check_output("hold_valid", 32'(mon_valid), 32'd0);
    check_output("hold_rdata", mon_rdata, 32'hDEADBEEF);

    // Sub-word loads with extension
    apply_stimulus(1'b0, 32'h13, MEM_B,  32'h0, rd, er, lat);
    check_output("lb_13",  rd, 32'hFFFFFFDE);
    apply_stimulus(1'b0, 32'h13, MEM_BU, 32'h0, rd, er, lat);
    check_output("lbu_13", rd, 32'h000000DE);
    apply_stimulus(1'b0, 32'h12, MEM_H,  32'h0, rd, er, lat);
    check_output("lh_12",  rd, 32'hFFFFDEAD);
    apply_stimulus(1'b0, 32'h10, MEM_HU, 32'h0, rd, er, lat);
    check_output("lhu_10", rd, 32'h0000BEEF);

    // Sub-word stores; upper wdata bits must not leak into other lanes
    apply_stimulus(1'b1, 32'h11, MEM_B, 32'hFFFFFF55, rd, er, lat);
    apply_stimulus(1'b0, 32'h10, MEM_W, 32'h0, rd, er, lat);
    check_output("sb_11", rd, 32'hDEAD55EF);
    apply_stimulus(1'b1, 32'h12, MEM_H, 32'hFFFF1234, rd, er, lat);
    apply_stimulus(1'b0, 32'h10, MEM_W, 32'h0, rd, er, lat);
    check_output("sh_12", rd, 32'h123455EF);

    // Error cases
    apply_stimulus(1'b0, 32'h12, MEM_W, 32'h0, rd, er, lat);
    check_output("lw_mis_err",   32'(er), 32'd1);
    check_output("lw_mis_rdata", rd, 32'h0);
    check_output("lw_mis_lat",   32'(lat), 32'd2);
    apply_stimulus(1'b1, 32'h11, MEM_H, 32'h0000BBBB, rd, er, lat);
    check_output("sh_mis_err", 32'(er), 32'd1);
    apply_stimulus(1'b0, 32'h10, 3'b011, 32'h0, rd, er, lat);
    check_output("f3_011_err",   32'(er), 32'd1);
    check_output("f3_011_rdata", rd, 32'h0);
    apply_stimulus(1'b1, 32'h10, MEM_BU, 32'h000000AA, rd, er, lat);
    check_output("sbu_err", 32'(er), 32'd1);
    apply_stimulus(1'b0, 32'h10, MEM_W, 32'h0, rd, er, lat);
    check_output("err_nowrite", rd, 32'h123455EF);

    // Out-of-range store must not alias onto word 0
    apply_stimulus(1'b1, 32'h0, MEM_W, 32'h11111111, rd, er, lat);
    apply_stimulus(1'b1, 32'h1000, MEM_W, 32'h99999999, rd, er, lat);
    check_output("oor_st_err", 32'(er), 32'd1);
    apply_stimulus(1'b0, 32'h1000, MEM_W, 32'h0, rd, er, lat);
    check_output("oor_ld_err",   32'(er), 32'd1);
    check_output("oor_ld_rdata", rd, 32'h0);
    apply_stimulus(1'b0, 32'h0, MEM_W, 32'h0, rd, er, lat);
    check_output("oor_nowrite", rd, 32'h11111111);

    // Three wait states
    @(negedge clk);
    sel = 1'b1;
    apply_stimulus(1'b1, 32'h20, MEM_W, 32'hCAFEF00D, rd, er, lat);
    check_output("ws3_sw_lat", 32'(lat), 32'd5);

    @(negedge clk);
    req_we     = 1'b0;
    req_addr   = 32'h20;
    req_funct3 = MEM_W;
    req_valid  = 1'b1;
    busy_tr = 8'h0;
    vld_tr  = 8'h0;
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      busy_tr[j] = mon_busy;
      vld_tr[j]  = mon_valid;
    end
    check_output("ws3_busy_trace",  32'(busy_tr), 32'h1E);
    check_output("ws3_valid_trace", 32'(vld_tr), 32'h20);
    check_output("ws3_lw_rdata", mon_rdata, 32'hCAFEF00D);
    @(negedge clk);
    check_output("b2b_idle_busy",  32'(mon_busy), 32'd0);
    check_output("b2b_idle_valid", 32'(mon_valid), 32'd0);
    @(negedge clk);
    check_output("b2b_accepted", 32'(mon_busy), 32'd1);
    req_addr   = 32'h12;
    req_funct3 = 3'b011;
    k = 7;
    while (!mon_valid && k < 30) begin
      @(negedge clk);
      k++;
    end
    check_output("b2b_rsp_cycle", 32'(k), 32'd11);
    check_output("b2b_rdata", mon_rdata, 32'hCAFEF00D);
    check_output("b2b_err",   32'(mon_err), 32'd0);
    req_valid = 1'b0;

    // Reset during the wait phase of a store
    @(negedge clk);
    req_we     = 1'b1;
    req_addr   = 32'h20;
    req_funct3 = MEM_W;
    req_wdata  = 32'h0BADBEEF;
    req_valid  = 1'b1;
    @(negedge clk);
    check_output("mid_busy", 32'(mon_busy), 32'd1);
    rst = 1'b1;
    #1;
    check_output("mid_rst_busy",  32'(mon_busy), 32'd0);
    check_output("mid_rst_valid", 32'(mon_valid), 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen = seen | mon_valid;
    end
    check_output("mid_no_rsp", 32'(seen), 32'd0);
    apply_stimulus(1'b0, 32'h20, MEM_W, 32'h0, rd, er, lat);
    check_output("mid_old_data", rd, 32'hCAFEF00D);

    sel = 1'b0;
    apply_stimulus(1'b0, 32'h10, MEM_W, 32'h0, rd, er, lat);
    check_output("ws0_after_rst", rd, 32'h123455EF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
